// File: rtl/tjmono_direct_rx_pkg.sv
// Shared constants, record layout and FSM state type for the direct-readout hit assembler.
package tjmono_direct_rx_pkg;

  localparam logic [1:0] IDX_CHUNK0  = 2'b00;
  localparam logic [1:0] IDX_CHUNK1  = 2'b01;
  localparam logic [1:0] IDX_CHUNK2  = 2'b10;
  localparam logic [1:0] IDX_TRAILER = 2'b11;

  localparam int unsigned CHUNK_W    = 28;
  localparam int unsigned REC_W      = 84;
  localparam int unsigned ROW_LSB    = 0;
  localparam int unsigned ROW_W      = 9;
  localparam int unsigned TE_LSB     = 9;
  localparam int unsigned TE_W       = 7;
  localparam int unsigned LE_LSB     = 16;
  localparam int unsigned LE_W       = 7;
  localparam int unsigned NOISE_BIT  = 23;
  localparam int unsigned TOKCNT_LSB = 24;
  localparam int unsigned TOKCNT_W   = 4;
  localparam int unsigned COL_LSB    = 28;
  localparam int unsigned COL_W      = 9;
  localparam int unsigned TS_LSB     = 37;
  localparam int unsigned TS_W       = 47;

  typedef enum logic [1:0] {StIdle, StGot0, StGot1, StGot2} state_e;

  typedef struct packed {
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [LE_W-1:0]     le;
    logic [TE_W-1:0]     te;
    logic [TE_W-1:0]     tot;
    logic [TS_W-1:0]     ts;
    logic [TOKCNT_W-1:0] token_cnt;
    logic                noise;
  } hit_t;

  // ToT wraps modulo 128 when the trailing edge counter has rolled over.
  function automatic hit_t unpack_rec(input logic [REC_W-1:0] rec);
    hit_t h;
    h.col       = rec[COL_LSB +: COL_W];
    h.row       = rec[ROW_LSB +: ROW_W];
    h.le        = rec[LE_LSB +: LE_W];
    h.te        = rec[TE_LSB +: TE_W];
    h.tot       = h.te - h.le;
    h.ts        = rec[TS_LSB +: TS_W];
    h.token_cnt = rec[TOKCNT_LSB +: TOKCNT_W];
    h.noise     = rec[NOISE_BIT];
    return h;
  endfunction

endpackage

// File: rtl/tjmono_direct_rx_hit_assembler_if.sv
// FIFO-side and hit-side signals of the hit assembler, grouped as one bus.
interface tjmono_direct_rx_hit_assembler_if;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_READ;
  logic        HIT_VALID;
  logic        HIT_READY;
  logic [8:0]  HIT_COL;
  logic [8:0]  HIT_ROW;
  logic [6:0]  HIT_LE;
  logic [6:0]  HIT_TE;
  logic [6:0]  HIT_TOT;
  logic [46:0] HIT_TS;
  logic [3:0]  HIT_TOKEN_CNT;
  logic        HIT_NOISE;

  modport master (
    input  FIFO_EMPTY, FIFO_DATA, HIT_READY,
    output FIFO_READ, HIT_VALID, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, HIT_TOT, HIT_TS,
           HIT_TOKEN_CNT, HIT_NOISE
  );

  modport slave (
    output FIFO_EMPTY, FIFO_DATA, HIT_READY,
    input  FIFO_READ, HIT_VALID, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, HIT_TOT, HIT_TS,
           HIT_TOKEN_CNT, HIT_NOISE
  );
endinterface

// File: rtl/tjmono_hit_outreg.sv
// One-entry valid/ready output register; a load in the accept cycle keeps HIT_VALID high.
module tjmono_hit_outreg
  import tjmono_direct_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [REC_W-1:0]     rec,
  tjmono_direct_rx_hit_assembler_if.master bus
);

  logic valid_q;
  hit_t hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      hit_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      hit_q   <= unpack_rec(rec);
    end else if (bus.HIT_READY) begin
      valid_q <= 1'b0;
      hit_q   <= '0;
    end
  end

  assign bus.HIT_VALID     = valid_q;
  assign bus.HIT_COL       = hit_q.col;
  assign bus.HIT_ROW       = hit_q.row;
  assign bus.HIT_LE        = hit_q.le;
  assign bus.HIT_TE        = hit_q.te;
  assign bus.HIT_TOT       = hit_q.tot;
  assign bus.HIT_TS        = hit_q.ts;
  assign bus.HIT_TOKEN_CNT = hit_q.token_cnt;
  assign bus.HIT_NOISE     = hit_q.noise;

endmodule

// File: rtl/tjmono_direct_rx_hit_assembler.sv
// Reassembles 4-word RX FIFO frames into 84-bit hit records with ID/sequence checking.
module tjmono_direct_rx_hit_assembler
  import tjmono_direct_rx_pkg::*;
#(
  parameter logic [3:0]  IDENTIFIER = 4'b0000,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 CONF_EN,
  input  logic                 CONF_DROP_NOISE,
  tjmono_direct_rx_hit_assembler_if.master bus,
  output logic [CNT_WIDTH-1:0] HIT_CNT,
  output logic [7:0]           FRAME_ERR_CNT,
  output logic [15:0]          NOISE_DROP_CNT
);

  state_e               state_q;
  logic [CHUNK_W-1:0]   chunk0_q, chunk1_q, chunk2_q;
  logic [CNT_WIDTH-1:0] hit_cnt_q;
  logic [7:0]           err_cnt_q;
  logic [15:0]          drop_cnt_q;

  logic [1:0]         idx;
  logic [CHUNK_W-1:0] payload;
  logic               id_ok, stall_trailer, pop, word_ok, frame_done, drop, load, err;

  assign idx     = bus.FIFO_DATA[29:28];
  assign payload = bus.FIFO_DATA[CHUNK_W-1:0];
  assign id_ok   = (bus.FIFO_DATA[31:30] == IDENTIFIER[1:0]);

  // Hold the trailer in the FIFO while the previous hit is still waiting to be taken.
  assign stall_trailer = (state_q == StGot2) && (idx == IDX_TRAILER) && id_ok &&
                         bus.HIT_VALID && !bus.HIT_READY;
  assign pop           = !BUS_RST && CONF_EN && !bus.FIFO_EMPTY && !stall_trailer;
  assign bus.FIFO_READ = pop;

  assign word_ok    = pop && id_ok;
  assign frame_done = word_ok && (state_q == StGot2) && (idx == IDX_TRAILER);
  assign drop       = frame_done && chunk0_q[NOISE_BIT] && CONF_DROP_NOISE;
  assign load       = frame_done && !drop;

  always_comb begin
    err = 1'b0;
    if (pop && !id_ok) begin
      err = 1'b1;
    end else if (word_ok) begin
      unique case (state_q)
        StIdle:  err = (idx != IDX_CHUNK0);
        StGot0:  err = (idx != IDX_CHUNK1);
        StGot1:  err = (idx != IDX_CHUNK2);
        StGot2:  err = (idx != IDX_TRAILER);
        default: err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q    <= StIdle;
      chunk0_q   <= '0;
      chunk1_q   <= '0;
      chunk2_q   <= '0;
      hit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (word_ok) begin
        // A chunk0 always (re)starts a frame, even when it arrives out of order.
        if (idx == IDX_CHUNK0) begin
          chunk0_q <= payload;
          state_q  <= StGot0;
        end else if (err) begin
          state_q <= StIdle;
        end else begin
          case (state_q)
            StGot0: begin
              chunk1_q <= payload;
              state_q  <= StGot1;
            end
            StGot1: begin
              chunk2_q <= payload;
              state_q  <= StGot2;
            end
            default: state_q <= StIdle;
          endcase
        end
      end
      if (err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 8'd1;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (load) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign HIT_CNT        = hit_cnt_q;
  assign FRAME_ERR_CNT  = err_cnt_q;
  assign NOISE_DROP_CNT = drop_cnt_q;

  tjmono_hit_outreg u_outreg (
    .clk  (BUS_CLK),
    .rst  (BUS_RST),
    .load (load),
    .rec  ({chunk2_q, chunk1_q, chunk0_q}),
    .bus  (bus)
  );

endmodule

// File: doc/tjmono_direct_rx_hit_assembler.md
Name: tjmono_direct_rx_hit_assembler

Overview:
- Consumes the 32-bit word stream from the direct-readout RX FIFO and reassembles each 4-word frame into one 84-bit hit record.
- A frame is three 28-bit payload chunks plus a trailer.
- Checks identifier and frame sequence, computes ToT, optionally drops possible-noise hits, and presents hits on a valid/ready port to the on-FPGA hit histogrammer / cluster stage.
- Sits between the RX FIFO and hit consumers, on the bus clock domain.

Parameters:
- IDENTIFIER, 4'b0000: expected word ID; compared against bits [31:30] only (IDENTIFIER[1:0]).
- CNT_WIDTH, 32: width of the HIT_CNT counter.

Ports:
- BUS_CLK  in  1  sole clock.
- BUS_RST  in  1  synchronous active-high reset.
- CONF_EN  in  1  enables reading; 0 stalls the block (FIFO_READ=0).
- CONF_DROP_NOISE  in  1  discard hits whose noise flag is set.
- FIFO_EMPTY  in  1  upstream FIFO empty.
- FIFO_DATA  in  32  upstream word; first-word-fall-through, valid while !FIFO_EMPTY.
- FIFO_READ  out  1  pops the current word.
- HIT_VALID  out  1  hit record valid.
- HIT_READY  in  1  consumer accepts the hit.
- HIT_COL  out  9; HIT_ROW  out  9; HIT_LE  out  7; HIT_TE  out  7; HIT_TOT  out  7.
- HIT_TS  out  47  token timestamp.
- HIT_TOKEN_CNT  out  4.
- HIT_NOISE  out  1.
- HIT_CNT  out  CNT_WIDTH  hits emitted.
- FRAME_ERR_CNT  out  8  frame/ID errors.
- NOISE_DROP_CNT  out  16  noise hits dropped.

Behaviour:
- Word format:
  - [31:30] ID; [29:28] index; [27:0] payload.
  - Index 00 -> record[27:0]; 01 -> [55:28]; 10 -> [83:56]; 11 -> trailer (payload ignored).
- Record fields: row [8:0], te [15:9], le [22:16], noise [23], token_cnt [27:24], col [36:28], ts [83:37]. Gray decoding is already done upstream.
- FIFO_READ = CONF_EN & !FIFO_EMPTY & !(state==GOT2 & idx==11 & ID ok & HIT_VALID & !HIT_READY).
  - The pop is combinational from current FIFO_DATA.
  - A word is consumed in the cycle FIFO_READ=1.
- Word with ID mismatch: popped, discarded, FRAME_ERR_CNT+1, state unchanged.
- FSM states: IDLE, GOT0, GOT1, GOT2. All transitions occur on popped words with matching ID.
  - IDLE: idx 00 stores chunk0 -> GOT0; any other idx discarded, error+1.
  - GOT0: idx 01 stores chunk1 -> GOT1.
  - GOT1: idx 10 stores chunk2 -> GOT2.
  - GOT2: idx 11 completes the frame -> IDLE.
  - Out-of-order word in GOT0/1/2: error+1. If idx==00, restart (store chunk0, go to GOT0); otherwise go to IDLE and discard the word.
- On frame completion:
  - If noise=1 & CONF_DROP_NOISE: drop the hit, NOISE_DROP_CNT+1.
  - Otherwise load the output register; HIT_VALID=1 the next cycle (latency 1 from trailer pop).
  - HIT_CNT+1 on load.
- Output register: holds fields stable while HIT_VALID & !HIT_READY. Clears on HIT_READY unless reloaded in the same cycle.
  - A simultaneous accept and trailer pop yields back-to-back hits with HIT_VALID continuously high.
- HIT_TOT = (te - le) mod 128, 7-bit wrap-around subtraction, registered with the other fields.
- Counters: FRAME_ERR_CNT and NOISE_DROP_CNT saturate at all-ones. HIT_CNT wraps.
- CONF_EN=0 mid-frame: the partial frame is retained and resumes when CONF_EN returns to 1. A pending HIT_VALID still drains.
- BUS_RST (any cycle, including mid-frame):
  - state=IDLE, chunks cleared.
  - HIT_VALID=0, all HIT_* fields 0.
  - All counters 0.
  - FIFO_READ=0 during reset.

Decomposition:
- Package tjmono_direct_rx_pkg holds:
  - index constants IDX_CHUNK0/1/2/TRAILER;
  - field offsets and widths (ROW_LSB, TE_LSB, LE_LSB, NOISE_BIT, TOKCNT_LSB, COL_LSB, TS_LSB, REC_W=84);
  - the state enum.
- One sub-module is natural: tjmono_hit_outreg, the one-entry valid/ready output register with load/accept arbitration.

Test Plan:
- Frame with col=0x1A5, row=0x0F3, le=10, te=25, ts=0x123456, noise=0, HIT_READY=1 -> one hit with matching fields, HIT_TOT=15, HIT_VALID exactly 1 cycle after trailer pop, HIT_CNT=1.
- Frame with le=120, te=5 -> HIT_TOT=13 (wrap-around).
- Index sequence 00,01,00,01,10,11 -> FRAME_ERR_CNT=1, one hit built from the second chunk0.
- Word with ID 01 injected mid-frame -> popped, FRAME_ERR_CNT=1, frame completes normally, one hit.
- noise=1 frames: with CONF_DROP_NOISE=1 -> no HIT_VALID, NOISE_DROP_CNT=1; with CONF_DROP_NOISE=0 -> hit emitted with HIT_NOISE=1.
- Back-pressure: 3 frames queued, HIT_READY=0 for 20 cycles -> FIFO_READ deasserts at the second trailer, first hit fields stable. Then HIT_READY=1 -> 3 hits delivered in order, none lost.
- BUS_RST asserted after chunk1 -> HIT_VALID=0, counters 0. Subsequent idx 10,11 words -> 2 errors, no hit.
